// File: rtl/led_frame_deserializer.sv
// led_frame_deserializer
// Collects decoded WS2812 bits into BITS_PER_LED-wide pixel words, captures
// NUM_LEDS pixels per frame into a one-entry output holding register with a
// valid/ready handshake, then switches to passthrough until the next treset.
// Optional build macro: LED_DESER_GRB_REORDER_EN (swap the two top bytes,
// turning wire order G,R,B[,W] into R,G,B[,W]).
module led_frame_deserializer #(
   parameter int BITS_PER_LED = 24,
   parameter int NUM_LEDS     = 1,
   parameter int IDX_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_decode_bit,
   input  logic                    i_valid_strobe,
   input  logic                    i_treset,
   output logic [BITS_PER_LED-1:0] o_led_data,
   output logic [IDX_W-1:0]        o_led_index,
   output logic                    o_led_valid,
   input  logic                    i_led_ready,
   output logic                    o_passthru_en,
   output logic                    o_overrun
);

   localparam int CNT_W = $clog2(BITS_PER_LED);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_LED - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

`ifdef LED_DESER_GRB_REORDER_EN
   generate
      if (BITS_PER_LED < 16) begin : g_reorder_width_check
         $error("LED_DESER_GRB_REORDER_EN requires BITS_PER_LED >= 16");
      end
   endgenerate
`endif

   typedef enum logic {
      CAPTURE  = 1'b0,
      PASSTHRU = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [BITS_PER_LED-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]        led_idx_q, led_idx_d;
   logic [BITS_PER_LED-1:0] hold_data_q, hold_data_d;
   logic [IDX_W-1:0]        hold_idx_q, hold_idx_d;
   logic                    hold_vld_q, hold_vld_d;
   logic                    overrun_q, overrun_d;

   logic [BITS_PER_LED-1:0] word_c;
   logic                    drain_c;

   // Byte reorder applied to each completed word before it is loaded.
   function automatic logic [BITS_PER_LED-1:0] reorder_word(
      input logic [BITS_PER_LED-1:0] w
   );
`ifdef LED_DESER_GRB_REORDER_EN
      logic [BITS_PER_LED-1:0] r;
      r = w;
      r[BITS_PER_LED-1 -: 8] = w[BITS_PER_LED-9 -: 8];
      r[BITS_PER_LED-9 -: 8] = w[BITS_PER_LED-1 -: 8];
      return r;
`else
      return w;
`endif
   endfunction

   assign word_c  = {shreg_q[BITS_PER_LED-2:0], i_decode_bit};
   assign drain_c = hold_vld_q && i_led_ready;

   // Next-state logic: handshake drain, treset recovery, bit capture and word load.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      led_idx_d   = led_idx_q;
      hold_data_d = hold_data_q;
      hold_idx_d  = hold_idx_q;
      hold_vld_d  = hold_vld_q;
      overrun_d   = overrun_q;

      if (drain_c) begin
         hold_vld_d = 1'b0;
      end

      if (i_treset) begin
         // A pending output word survives treset; only capture state restarts.
         state_d   = CAPTURE;
         shreg_d   = '0;
         bit_cnt_d = '0;
         led_idx_d = '0;
         overrun_d = 1'b0;
      end else if (state_q == CAPTURE && i_valid_strobe) begin
         shreg_d = word_c;
         if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            // Load when empty or when the current word drains on this same edge.
            if (!hold_vld_q || i_led_ready) begin
               hold_data_d = reorder_word(word_c);
               hold_idx_d  = led_idx_q;
               hold_vld_d  = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
            if (led_idx_q == LAST_IDX) begin
               state_d = PASSTHRU;
            end else begin
               led_idx_d = led_idx_q + IDX_W'(1);
            end
         end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
      end
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= CAPTURE;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         led_idx_q   <= '0;
         hold_data_q <= '0;
         hold_idx_q  <= '0;
         hold_vld_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         led_idx_q   <= led_idx_d;
         hold_data_q <= hold_data_d;
         hold_idx_q  <= hold_idx_d;
         hold_vld_q  <= hold_vld_d;
         overrun_q   <= overrun_d;
      end
   end

   assign o_led_data    = hold_data_q;
   assign o_led_index   = hold_idx_q;
   assign o_led_valid   = hold_vld_q;
   assign o_passthru_en = (state_q == PASSTHRU);
   assign o_overrun     = overrun_q;

endmodule
